// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory port.
// The arbiter uses the slave view; requesters and memory model use the master view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data requests win, except a fetch that has lost
// STARVE_MAX consecutive cycles; read data returns one cycle after the grant.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned CW_RAW = $clog2(STARVE_MAX + 1);
    localparam int unsigned CW     = (CW_RAW < 2) ? 2 : CW_RAW;

    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_IF,
        RSP_D
    } rsp_t;

    rsp_t          rsp;
    logic [CW-1:0] starve_cnt;
    logic          starved;
    logic          if_gnt_c;
    logic          d_gnt_c;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        if (!reset) begin
            if (bus.if_req && bus.d_req) begin
                if_gnt_c = starved;
                d_gnt_c  = !starved;
            end else begin
                if_gnt_c = bus.if_req;
                d_gnt_c  = bus.d_req;
            end
        end
    end

    assign bus.if_gnt = if_gnt_c;
    assign bus.d_gnt  = d_gnt_c;
    assign bus.mem_en = if_gnt_c | d_gnt_c;
    assign bus.mem_we = d_gnt_c & bus.d_we;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (if_gnt_c) begin
            bus.mem_addr = bus.if_addr;
        end else if (d_gnt_c) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            rsp        <= RSP_NONE;
        end else begin
            if (bus.if_req && !if_gnt_c) begin
                if (!starved)
                    starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end

            if (if_gnt_c)
                rsp <= RSP_IF;
            else if (d_gnt_c && !bus.d_we)
                rsp <= RSP_D;
            else
                rsp <= RSP_NONE;
        end
    end

    // Gating with reset drops a read whose response would land in a reset cycle.
    assign bus.if_rvalid = (rsp == RSP_IF) && !reset;
    assign bus.d_rvalid  = (rsp == RSP_D) && !reset;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a cycle-level model of
// the arbitration, starvation and read-return rules.
module tb_mem_arbiter;
    localparam int unsigned SM = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state
    int unsigned lost   = 0;
    logic        pend_if = 1'b0;
    logic        pend_d  = 1'b0;
    logic        m_ig, m_dg;

    // stimulus state
    logic        ir = 1'b0, dr = 1'b0, dw = 1'b0;
    logic [31:0] ia = '0, da = '0, dd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst);
        logic [31:0] rd;
        logic        e_if_rv, e_d_rv;
        @(posedge clk);
        #1;
        reset        = rst;
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.d_req    = dr;
        bus.d_we     = dw;
        bus.d_addr   = da;
        bus.d_wdata  = dd;
        rd           = $urandom;
        bus.mem_rdata = rd;
        #3;
        if (rst) begin
            m_ig = 1'b0;
            m_dg = 1'b0;
        end else if (ir && dr) begin
            m_ig = (lost >= SM);
            m_dg = !m_ig;
        end else begin
            m_ig = ir;
            m_dg = dr;
        end
        e_if_rv = pend_if && !rst;
        e_d_rv  = pend_d && !rst;
        check("if_gnt",    32'(bus.if_gnt), 32'(m_ig));
        check("d_gnt",     32'(bus.d_gnt),  32'(m_dg));
        check("mem_en",    32'(bus.mem_en), 32'(m_ig | m_dg));
        check("mem_we",    32'(bus.mem_we), 32'(m_dg & dw));
        check("mem_addr",  bus.mem_addr,  m_ig ? ia : (m_dg ? da : 32'h0));
        check("mem_wdata", bus.mem_wdata, m_dg ? dd : 32'h0);
        check("if_rvalid", 32'(bus.if_rvalid), 32'(e_if_rv));
        check("d_rvalid",  32'(bus.d_rvalid),  32'(e_d_rv));
        check("if_rdata",  bus.if_rdata, e_if_rv ? rd : 32'h0);
        check("d_rdata",   bus.d_rdata,  e_d_rv ? rd : 32'h0);
        if (rst) begin
            lost    = 0;
            pend_if = 1'b0;
            pend_d  = 1'b0;
        end else begin
            lost    = (ir && !m_ig) ? ((lost + 1 > SM) ? SM : lost + 1) : 0;
            pend_if = m_ig;
            pend_d  = m_dg && !dw;
        end
    endtask

    task automatic idle();
        ir = 1'b0; dr = 1'b0; dw = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;

        // reset state, with requests present that must be ignored
        ir = 1'b1; dr = 1'b1; ia = 32'h4; da = 32'h8;
        step(1'b1);
        step(1'b1);
        idle();
        step(1'b0);

        // lone fetch, data returns next cycle
        ir = 1'b1; ia = 32'h8;
        step(1'b0);
        check("lone_fetch_gnt", 32'(bus.if_gnt), 32'h1);
        check("lone_fetch_addr", bus.mem_addr, 32'h8);
        idle();
        step(1'b0);
        check("lone_fetch_rvalid", 32'(bus.if_rvalid), 32'h1);

        // store: no rvalid afterwards
        dr = 1'b1; dw = 1'b1; da = 32'h40; dd = 32'hDEADBEEF;
        step(1'b0);
        check("store_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("store_we", 32'(bus.mem_we), 32'h1);
        idle();
        step(1'b0);
        check("store_no_rvalid", 32'(bus.d_rvalid | bus.if_rvalid), 32'h0);

        // both continuous: D,D,D,IF repeating
        ir = 1'b1; ia = 32'h100; dr = 1'b1; dw = 1'b0; da = 32'h200;
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("starve_order", 32'(bus.if_gnt), (i % 4 == 3) ? 32'h1 : 32'h0);
        end

        // d_req dropped one cycle: fetch wins and the loss count restarts
        step(1'b0);
        step(1'b0);
        dr = 1'b0;
        step(1'b0);
        check("drop_fetch_gnt", 32'(bus.if_gnt), 32'h1);
        dr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("drop_restart", 32'(bus.if_gnt), (i == 3) ? 32'h1 : 32'h0);
        end

        // load then fetch: d_rvalid alongside if_gnt, then if_rvalid
        idle();
        step(1'b0);
        dr = 1'b1; da = 32'h10;
        step(1'b0);
        dr = 1'b0; ir = 1'b1; ia = 32'h20;
        step(1'b0);
        check("pipe_d_rvalid", 32'({bus.d_rvalid, bus.if_gnt}), 32'h3);
        idle();
        step(1'b0);
        check("pipe_if_rvalid", 32'({bus.d_rvalid, bus.if_rvalid}), 32'h1);

        // reset right after a load grant suppresses the return
        dr = 1'b1; da = 32'h10;
        step(1'b0);
        idle();
        step(1'b1);
        check("reset_kills_rvalid", 32'(bus.d_rvalid), 32'h0);
        step(1'b0);

        // randomized traffic obeying the hold-until-granted protocol
        for (int n = 0; n < 3000; n++) begin
            if (ir && !m_ig && $urandom_range(7) == 0) begin
                ir = 1'b0;
            end else if (!ir || m_ig) begin
                ir = 1'($urandom_range(1));
                ia = $urandom & 32'hFFFF_FFFC;
            end
            if (dr && !m_dg && $urandom_range(7) == 0) begin
                dr = 1'b0;
            end else if (!dr || m_dg) begin
                dr = 1'($urandom_range(1));
                dw = 1'($urandom_range(1));
                da = $urandom;
                dd = $urandom;
            end
            step($urandom_range(39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
